ps2_kbd_rx: RTL and testbench

- Keyboard-side responder for the CPU MMIO read path.
- Deserialises PS/2 device frames (ps2_clk/ps2_data) into 8-bit scan codes and buffers them in a small FIFO.
- Presents the FIFO head as kb_rdata/kb_ready to the MMIO decoder.
- Pops one entry per clock cycle in which the decoder asserts sig_rd_kb.

---
 rtl/ps2_kbd_rx_pkg.sv | 12 +
 rtl/ps2_kbd_rx_if.sv | 10 +
 rtl/kbd_fifo.sv | 41 ++++
 rtl/ps2_kbd_rx.sv | 107 ++++++++++
 tb/tb_ps2_kbd_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_kbd_rx_pkg: widths and defaults shared by the MMIO decoder and the PS/2 keyboard receiver.
// No ports; provides KbWidth, PS2_FRAME_BITS, KBD_FIFO_DEPTH, KBD_TIMEOUT_CYC and a parity helper.
package ps2_kbd_rx_pkg;
    localparam int KbWidth         = 8;
    localparam int PS2_FRAME_BITS  = 11;
    localparam int KBD_FIFO_DEPTH  = 8;
    localparam int KBD_TIMEOUT_CYC = 50000;

    function automatic logic odd_parity_ok(input logic [KbWidth-1:0] b, input logic p);
        return ^{b, p};
    endfunction
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: MMIO read handshake between the decoder (master) and the keyboard block (slave).
// sig_rd_kb: pop request; kb_rdata: FIFO head scan code; kb_ready: FIFO non-empty.
interface ps2_kbd_rx_if;
    import ps2_kbd_rx_pkg::*;
    logic               sig_rd_kb;
    logic [KbWidth-1:0] kb_rdata;
    logic               kb_ready;
    modport master (output sig_rd_kb, input kb_rdata, kb_ready);
    modport slave  (input sig_rd_kb, output kb_rdata, kb_ready);
endinterface

// File: rtl/kbd_fifo.sv
// kbd_fifo: show-ahead FIFO with wrap-bit pointers.
// Ports: clk, rst (async high), push/din write side, pop read side, dout head (0 when empty), full, empty.
module kbd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver feeding a scan-code FIFO on the MMIO read path.
// Ports: clk, rst (async high), ps2_clk/ps2_data raw device lines, kb (slave: sig_rd_kb, kb_rdata, kb_ready),
// overflow (sticky byte-dropped flag), frame_err (one-cycle bad-frame/timeout pulse).
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = KBD_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = KBD_TIMEOUT_CYC,
    parameter int SYNC_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    ps2_kbd_rx_if.slave kb,
    output logic        overflow,
    output logic        frame_err
);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic [1:0]             state;
    logic [2:0]             bit_cnt;
    logic [KbWidth-1:0]     shreg;
    logic                   par;
    logic [TW-1:0]          tcnt;
    logic                   fall, din, push, full, empty;

    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign din  = data_sync[SYNC_STAGES-1];
    // Push straight off the stop-bit edge so the byte is visible one clk later.
    assign push = fall && state == STOP && din && odd_parity_ok(shreg, par);
    assign kb.kb_ready = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: if (!din) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {din, shreg[KbWidth-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(PS2_FRAME_BITS - 4)) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= din;
                        state <= STOP;
                    end
                    default: begin
                        frame_err <= ~(din && odd_parity_ok(shreg, par));
                        state     <= IDLE;
                    end
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYC)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tcnt      <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // A full FIFO with a concurrent pop accepts the byte, so only an unpopped full push drops it.
    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else if (push && full && !kb.sig_rd_kb) overflow <= 1'b1;

    kbd_fifo #(.WIDTH(KbWidth), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg),
        .pop   (kb.sig_rd_kb),
        .dout  (kb.kb_rdata),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed bench for ps2_kbd_rx driving PS/2 frames and MMIO pops.
module tb_ps2_kbd_rx;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic overflow, frame_err;
    int   errors = 0;
    int   checks = 0;
    int   err_pulses = 0;

    ps2_kbd_rx_if kb_if ();

    ps2_kbd_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TO), .SYNC_STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb        (kb_if.slave),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        kb_if.sig_rd_kb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop_v,
                              input logic pop_sync, input logic chk);
        logic p;
        p = ~(^b) ^ flip;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        @(negedge clk);
        ps2_data = stop_v;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        checks += chk ? 1 : 0;
        if (chk && kb_if.kb_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat_early kb_ready=%b exp=0", kb_if.kb_ready);
        end
        if (pop_sync) kb_if.sig_rd_kb = 1'b1;
        @(negedge clk);
        kb_if.sig_rd_kb = 1'b0;
        checks += chk ? 2 : 0;
        if (chk && kb_if.kb_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_ready kb_ready=%b exp=1", kb_if.kb_ready);
        end
        if (chk && kb_if.kb_rdata !== b) begin
            errors++;
            $display("FAIL lat_data kb_rdata=%h exp=%h", kb_if.kb_rdata, b);
        end
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_pop();
        @(negedge clk);
        kb_if.sig_rd_kb = 1'b1;
        @(negedge clk);
        kb_if.sig_rd_kb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", kb_if.kb_ready); end
        if (kb_if.kb_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", kb_if.kb_rdata); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_single_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
        do_pop();
        checks += 2;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL single_pop_ready got=%b exp=0", kb_if.kb_ready); end
        if (kb_if.kb_rdata !== 8'h00) begin errors++; $display("FAIL single_pop_rdata got=%h exp=00", kb_if.kb_rdata); end
        do_pop();
        checks++;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ready got=%b exp=0", kb_if.kb_ready); end
    endtask

    task automatic test_two_frames();
        int e0;
        e0 = err_pulses;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (kb_if.kb_ready !== 1'b1) begin errors++; $display("FAIL two_ready got=%b exp=1", kb_if.kb_ready); end
        if (kb_if.kb_rdata !== 8'hF0) begin errors++; $display("FAIL two_head0 got=%h exp=f0", kb_if.kb_rdata); end
        do_pop();
        checks++;
        if (kb_if.kb_rdata !== 8'h1C) begin errors++; $display("FAIL two_head1 got=%h exp=1c", kb_if.kb_rdata); end
        do_pop();
        checks += 2;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL two_empty got=%b exp=0", kb_if.kb_ready); end
        if (err_pulses !== e0) begin errors++; $display("FAIL two_no_err pulses=%0d exp=%0d", err_pulses, e0); end
    endtask

    task automatic test_bad_frames();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (err_pulses !== e0 + 1) begin errors++; $display("FAIL parity_err pulses=%0d exp=%0d", err_pulses, e0 + 1); end
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL parity_ready got=%b exp=0", kb_if.kb_ready); end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (err_pulses !== e0 + 2) begin errors++; $display("FAIL stop_err pulses=%0d exp=%0d", err_pulses, e0 + 2); end
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL stop_ready got=%b exp=0", kb_if.kb_ready); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i);
            send_frame(v, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        send_frame(8'h09, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i);
            checks++;
            if (kb_if.kb_rdata !== v) begin errors++; $display("FAIL ovf_head%0d got=%h exp=%h", i, kb_if.kb_rdata, v); end
            do_pop();
        end
        checks += 2;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", kb_if.kb_ready); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = 8'h10 + 8'(i);
            send_frame(v, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 7; i++) begin
            v = 8'h11 + 8'(i);
            checks++;
            if (kb_if.kb_rdata !== v) begin errors++; $display("FAIL full_pp_head%0d got=%h exp=%h", i, kb_if.kb_rdata, v); end
            do_pop();
        end
        checks++;
        if (kb_if.kb_rdata !== 8'h55) begin errors++; $display("FAIL full_pp_last got=%h exp=55", kb_if.kb_rdata); end
        do_pop();
        checks++;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL full_pp_empty got=%b exp=0", kb_if.kb_ready); end
    endtask

    task automatic test_timeout();
        int  e0;
        logic seen;
        do_reset();
        e0 = err_pulses;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO - 40) @(negedge clk);
        checks++;
        if (err_pulses !== e0) begin errors++; $display("FAIL to_early pulses=%0d exp=%0d", err_pulses, e0); end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = err_pulses != e0;
        end
        repeat (4) @(negedge clk);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL to_fire pulses=%0d exp=%0d", err_pulses, e0 + 1); end
        else if (err_pulses !== e0 + 1) begin errors++; $display("FAIL to_pulse pulses=%0d exp=%0d", err_pulses, e0 + 1); end
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL to_ready got=%b exp=0", kb_if.kb_ready); end
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (kb_if.kb_rdata !== 8'h2A) begin errors++; $display("FAIL to_next got=%h exp=2a", kb_if.kb_rdata); end
        if (err_pulses !== e0 + 1) begin errors++; $display("FAIL to_next_err pulses=%0d exp=%0d", err_pulses, e0 + 1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(8'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hB2, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (kb_if.kb_rdata !== 8'hA1) begin errors++; $display("FAIL mid_pre got=%h exp=a1", kb_if.kb_rdata); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks += 3;
        if (kb_if.kb_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", kb_if.kb_ready); end
        if (kb_if.kb_rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata got=%h exp=00", kb_if.kb_rdata); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (kb_if.kb_rdata !== 8'h33) begin errors++; $display("FAIL mid_after got=%h exp=33", kb_if.kb_rdata); end
    endtask

    initial begin
        kb_if.sig_rd_kb = 1'b0;
        test_reset();
        test_single_frame();
        test_two_frames();
        test_bad_frames();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
